buzzer_player: RTL and testbench

BUZZER_PLAYER -- requirements
Module: buzzer_player

---
 rtl/buzzer_player.sv | 147 ++++++++++++++
 tb/tb_buzzer_player.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/buzzer_player.sv
// Plays a latched beep pattern MSB-first as fixed-length slots of square-wave tone or silence.
// Optional BUZZER_LOOP_EN adds a 'loop' input that repeats the pattern back-to-back.
module buzzer_player #(
  parameter int UNIT_CYCLES = 25_000_000,
  parameter int TONE_HALF   = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
`ifdef BUZZER_LOOP_EN
  input  logic        loop,
`endif
  input  logic [74:0] beep_bit,
  input  logic [6:0]  wid,
  output logic        buzzer,
  output logic        busy,
  output logic        done
);

  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);
  localparam logic [6:0]    MAX_LEN   = 7'd75;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } state_t;

  state_t      state, state_next;
  logic [74:0] pattern, pattern_next;
  logic [6:0]  len, len_next;
  logic [6:0]  idx, idx_next;
  logic [UW-1:0] slot_cnt, slot_cnt_next;
  logic [TW-1:0] tone_cnt, tone_cnt_next;
  logic        buzzer_next;
  logic        loop_req;
  logic        slot_end;
  logic [6:0]  wid_clamped;

`ifdef BUZZER_LOOP_EN
  assign loop_req = loop;
`else
  assign loop_req = 1'b0;
`endif

  assign wid_clamped = (wid > MAX_LEN) ? MAX_LEN : wid;
  assign slot_end    = (slot_cnt == UNIT_LAST);
  assign busy        = (state == PLAY);
  assign done        = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pattern  <= '0;
      len      <= '0;
      idx      <= '0;
      slot_cnt <= '0;
      tone_cnt <= '0;
      buzzer   <= 1'b0;
    end else begin
      state    <= state_next;
      pattern  <= pattern_next;
      len      <= len_next;
      idx      <= idx_next;
      slot_cnt <= slot_cnt_next;
      tone_cnt <= tone_cnt_next;
      buzzer   <= buzzer_next;
    end
  end

  always_comb begin
    state_next    = state;
    pattern_next  = pattern;
    len_next      = len;
    idx_next      = idx;
    slot_cnt_next = slot_cnt;
    tone_cnt_next = tone_cnt;
    buzzer_next   = buzzer;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          if (wid == 7'd0) begin
            state_next = DONE;
          end else begin
            pattern_next  = beep_bit;
            len_next      = wid_clamped;
            idx_next      = wid_clamped - 7'd1;
            slot_cnt_next = '0;
            tone_cnt_next = '0;
            buzzer_next   = 1'b0;
            state_next    = PLAY;
          end
        end
      end

      PLAY: begin
        // Abort wins over a slot boundary landing on the same cycle.
        if (stop) begin
          state_next    = IDLE;
          slot_cnt_next = '0;
          tone_cnt_next = '0;
          idx_next      = '0;
          buzzer_next   = 1'b0;
        end else if (slot_end) begin
          slot_cnt_next = '0;
          tone_cnt_next = '0;
          buzzer_next   = 1'b0;
          if (idx != 7'd0) begin
            idx_next = idx - 7'd1;
          end else if (loop_req) begin
            idx_next = len - 7'd1;
          end else begin
            state_next = DONE;
          end
        end else begin
          slot_cnt_next = slot_cnt + 1'b1;
          if (pattern[idx]) begin
            if (tone_cnt == TONE_LAST) begin
              tone_cnt_next = '0;
              buzzer_next   = ~buzzer;
            end else begin
              tone_cnt_next = tone_cnt + 1'b1;
            end
          end else begin
            buzzer_next = 1'b0;
          end
        end
      end

      DONE: begin
        state_next  = IDLE;
        buzzer_next = 1'b0;
      end

      default: begin
        state_next  = IDLE;
        buzzer_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_buzzer_player.sv
// Table-driven bench for buzzer_player with UNIT_CYCLES=4, TONE_HALF=1.
// The loop sequence is only built when BUZZER_LOOP_EN is defined.
module tb_buzzer_player;

  localparam int UNIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [74:0] beep_bit = '0;
  logic [6:0]  wid = '0;
  logic        buzzer;
  logic        busy;
  logic        done;
`ifdef BUZZER_LOOP_EN
  logic        loop = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [74:0] pat;
    logic [6:0]  wid;
    int          exp_len;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  buzzer_player #(
    .UNIT_CYCLES(4),
    .TONE_HALF(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
`ifdef BUZZER_LOOP_EN
    .loop(loop),
`endif
    .beep_bit(beep_bit),
    .wid(wid),
    .buzzer(buzzer),
    .busy(busy),
    .done(done)
  );

  task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: {busy,done,buzzer} got %b, expected %b", name, actual, expected);
    end
  endtask

  // Expected {busy,done,buzzer} at a given cycle after the start edge.
  function automatic logic [2:0] modelOut(input logic [74:0] pat, input int len, input int cyc);
    int bit_idx;
    if (cyc < len * UNIT) begin
      bit_idx = len - 1 - cyc / UNIT;
      return {1'b1, 1'b0, (pat[bit_idx] && ((cyc % UNIT) % 2 == 1))};
    end else if (cyc == len * UNIT) begin
      return 3'b010;
    end
    return 3'b000;
  endfunction

  task automatic applyStimulus(input logic [74:0] pat, input logic [6:0] w);
    @(negedge clk);
    beep_bit = pat;
    wid      = w;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    beep_bit = ~pat;
    wid      = ~w;
  endtask

  // Walks the whole playback cycle by cycle; pokes a stray start mid-play.
  task automatic monitorVector(input string name, input logic [74:0] pat, input int len);
    for (int cyc = 0; cyc <= len * UNIT + 2; cyc++) begin
      if (cyc > 0) @(negedge clk);
      checkOutput($sformatf("%s cyc%0d", name, cyc), {busy, done, buzzer}, modelOut(pat, len, cyc));
      start = (cyc == 5 && cyc < len * UNIT);
    end
    start = 1'b0;
  endtask

  task automatic runVector(input string name, input logic [74:0] pat, input logic [6:0] w, input int len);
    applyStimulus(pat, w);
    monitorVector(name, pat, len);
  endtask

  initial begin
    vecs[0] = '{pat: 75'h1F,  wid: 7'd8,   exp_len: 8};
    vecs[1] = '{pat: '1,      wid: 7'd0,   exp_len: 0};
    vecs[2] = '{pat: '1,      wid: 7'd100, exp_len: 75};
    vecs[3] = '{pat: 75'hA,   wid: 7'd4,   exp_len: 4};
    vecs[4] = '{pat: 75'h5A5, wid: 7'd12,  exp_len: 12};
    vecs[5] = '{pat: 75'h1,   wid: 7'd1,   exp_len: 1};
    vecs[6] = '{pat: {1'b1, 74'b0}, wid: 7'd127, exp_len: 75};
    vecs[7] = '{pat: 75'h2,   wid: 7'd2,   exp_len: 2};

    #12;
    checkOutput("reset", {busy, done, buzzer}, 3'b000);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i].pat, vecs[i].wid, vecs[i].exp_len);
    end

    // Abort in the third slot, then replay from the top bit.
    applyStimulus(75'hFF, 7'd8);
    for (int cyc = 0; cyc <= 9; cyc++) begin
      if (cyc > 0) @(negedge clk);
      checkOutput($sformatf("prestop cyc%0d", cyc), {busy, done, buzzer}, modelOut(75'hFF, 8, cyc));
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checkOutput("stop abort", {busy, done, buzzer}, 3'b000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("stop no done %0d", k), {busy, done, buzzer}, 3'b000);
    end
    runVector("replay", 75'h80, 7'd8, 8);

    // Stop on the very last cycle of the final slot suppresses done.
    applyStimulus(75'h1, 7'd1);
    for (int cyc = 0; cyc <= 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      checkOutput($sformatf("prio cyc%0d", cyc), {busy, done, buzzer}, modelOut(75'h1, 1, cyc));
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checkOutput("stop priority", {busy, done, buzzer}, 3'b000);
    @(negedge clk);
    checkOutput("stop priority after", {busy, done, buzzer}, 3'b000);

    // start and stop together in IDLE must not launch playback.
    @(negedge clk);
    beep_bit = 75'hF;
    wid      = 7'd4;
    start    = 1'b1;
    stop     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("start+stop idle", {busy, done, buzzer}, 3'b000);
    @(negedge clk);
    checkOutput("start+stop idle after", {busy, done, buzzer}, 3'b000);

    // Asynchronous reset in the middle of a tone, then immediate restart.
    applyStimulus(75'h1, 7'd1);
    @(negedge clk);
    checkOutput("pre-reset tone", {busy, done, buzzer}, 3'b101);
    #2 rst = 1'b0;
    #1 checkOutput("async reset", {busy, done, buzzer}, 3'b000);
    #1 rst = 1'b1;
    beep_bit = 75'h3;
    wid      = 7'd2;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    beep_bit = '0;
    wid      = 7'd0;
    monitorVector("post-reset", 75'h3, 2);

`ifdef BUZZER_LOOP_EN
    // Two back-to-back passes, loop dropped during the second.
    loop = 1'b1;
    applyStimulus(75'h9, 7'd4);
    for (int cyc = 0; cyc <= 34; cyc++) begin
      if (cyc > 0) @(negedge clk);
      checkOutput($sformatf("loop cyc%0d", cyc), {busy, done, buzzer},
                  modelOut(75'h9, 4, (cyc < 16) ? cyc : cyc - 16));
      if (cyc == 20) loop = 1'b0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
